// File: rtl/mem_access.sv
// Memory stage: drives a req/ready data-memory port with store lane alignment and
// load extraction, stalls upstream while an access is outstanding, registers the WB bundle.
module mem_access #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic                  wb_enable_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    output logic                  stall_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic                  dmem_ready_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  wb_valid_o,
    output logic                  wb_enable_o,
    output logic [REG_ADDR_W-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  misalign_o
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_is_load;
    logic                  r_wb_en;
    logic [REG_ADDR_W-1:0] r_wb_addr;

    logic                  w_is_mem;
    logic                  w_is_store;
    logic [1:0]            w_size;
    logic                  w_misalign;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdata_sh;
    logic [DATA_WIDTH-1:0] w_load;

    // Size code: 0 byte, 1 half, 2 word; undefined encodings fall back to word.
    always_comb begin
        w_is_mem   = mem_read_i | mem_write_i;
        w_is_store = mem_write_i;
        case (funct3_i[1:0])
            2'b00:   w_size = 2'd0;
            2'b01:   w_size = 2'd1;
            default: w_size = 2'd2;
        endcase
        w_misalign = ((w_size == 2'd1) && alu_result_i[0]) ||
                     ((w_size == 2'd2) && (alu_result_i[1:0] != 2'b00));
        w_be    = 4'b1111;
        w_wdata = store_data_i;
        if (w_is_store) begin
            case (w_size)
                2'd0: begin
                    w_be    = 4'b0001 << alu_result_i[1:0];
                    w_wdata = {4{store_data_i[7:0]}};
                end
                2'd1: begin
                    w_be    = 4'b0011 << alu_result_i[1:0];
                    w_wdata = {2{store_data_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdata_sh = dmem_rdata_i >> {r_lane, 3'b000};
        case (r_size)
            2'd0:    w_load = r_unsigned ? {24'd0, w_rdata_sh[7:0]}
                                         : {{24{w_rdata_sh[7]}}, w_rdata_sh[7:0]};
            2'd1:    w_load = r_unsigned ? {16'd0, w_rdata_sh[15:0]}
                                         : {{16{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
            default: w_load = dmem_rdata_i;
        endcase
    end

    // Gated by rst so every output reads 0 while reset is held, even with EX inputs active.
    always_comb begin
        stall_o = 1'b0;
        if (!rst) begin
            if (r_state == IDLE)
                stall_o = valid_i && w_is_mem && !w_misalign;
            else
                stall_o = !dmem_ready_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lane       <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_is_load    <= 1'b0;
            r_wb_en      <= 1'b0;
            r_wb_addr    <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_enable_o  <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            misalign_o   <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        if (!w_is_mem) begin
                            wb_valid_o  <= 1'b1;
                            wb_enable_o <= wb_enable_i;
                            wb_addr_o   <= wb_addr_i;
                            wb_data_o   <= alu_result_i;
                        end else if (w_misalign) begin
                            wb_valid_o  <= 1'b1;
                            wb_enable_o <= 1'b0;
                            wb_addr_o   <= wb_addr_i;
                            wb_data_o   <= alu_result_i;
                            misalign_o  <= 1'b1;
                        end else begin
                            r_state      <= ACCESS;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= w_is_store;
                            dmem_addr_o  <= {alu_result_i[DATA_WIDTH-1:2], 2'b00};
                            dmem_be_o    <= w_be;
                            dmem_wdata_o <= w_is_store ? w_wdata : '0;
                            r_lane       <= alu_result_i[1:0];
                            r_size       <= w_size;
                            r_unsigned   <= funct3_i[2];
                            r_is_load    <= !w_is_store;
                            r_wb_en      <= wb_enable_i && !w_is_store;
                            r_wb_addr    <= wb_addr_i;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ready_i) begin
                        r_state     <= IDLE;
                        dmem_req_o  <= 1'b0;
                        dmem_we_o   <= 1'b0;
                        wb_valid_o  <= 1'b1;
                        wb_enable_o <= r_wb_en;
                        wb_addr_o   <= r_wb_addr;
                        wb_data_o   <= r_is_load ? w_load : '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized instructions
// checked against an arithmetic reference model of the memory stage.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [2:0]  funct3_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        wb_enable_i;
    logic [4:0]  wb_addr_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_enable_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    // Pending writeback expected to be visible in the next sampled cycle.
    logic        p_valid = 1'b0;
    logic        p_en;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        p_chk_data;
    logic        p_mis = 1'b0;

    mem_access #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .funct3_i(funct3_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .wb_enable_i(wb_enable_i), .wb_addr_i(wb_addr_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_enable_o(wb_enable_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks stall/req plus the writeback and misalign outputs for the current cycle.
    task automatic sample(input string tag, input logic exp_stall, input logic exp_req);
        chk({tag, ".stall"}, 32'(stall_o), 32'(exp_stall));
        chk({tag, ".req"}, 32'(dmem_req_o), 32'(exp_req));
        chk({tag, ".wb_valid"}, 32'(wb_valid_o), 32'(p_valid));
        chk({tag, ".misalign"}, 32'(misalign_o), 32'(p_mis));
        if (p_valid) begin
            chk({tag, ".wb_en"}, 32'(wb_enable_o), 32'(p_en));
            chk({tag, ".wb_addr"}, 32'(wb_addr_o), 32'(p_addr));
            if (p_chk_data) chk({tag, ".wb_data"}, wb_data_o, p_data);
        end
        p_valid = 1'b0;
        p_mis   = 1'b0;
    endtask

    task automatic bubble();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        dmem_ready_i = 1'($urandom); dmem_rdata_i = $urandom;
        #3;
        sample("bubble", 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    // Presents one instruction, holds it while stalled, checks the memory port
    // every cycle, and records the expected writeback for the following cycle.
    // lat = number of ACCESS cycles without ready before the ready cycle.
    task automatic run(input string tag, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [2:0] f3, input logic rd, input logic wr,
                       input logic wbe, input logic [4:0] wba, input int lat,
                       input logic [31:0] rdata);
        int          nbytes;
        int          lane;
        logic        is_mem;
        logic        mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] mask;
        logic [31:0] e_load;
        is_mem = rd | wr;
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lane   = int'(addr % 4);
        mis    = is_mem && ((addr % nbytes) != 0);
        e_be   = wr ? 4'(((1 << nbytes) - 1) << lane) : 4'hF;
        e_wdata = (nbytes == 1) ? sd[7:0] * 32'h0101_0101 :
                  (nbytes == 2) ? sd[15:0] * 32'h0001_0001 : sd;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nbytes)) - 1;
        e_load = (rdata >> (8 * lane)) & mask;
        if (nbytes < 4 && !f3[2] && e_load[8 * nbytes - 1]) e_load = e_load | ~mask;

        valid_i = 1'b1; alu_result_i = addr; store_data_i = sd; funct3_i = f3;
        mem_read_i = rd; mem_write_i = wr; wb_enable_i = wbe; wb_addr_i = wba;
        dmem_ready_i = 1'($urandom); dmem_rdata_i = $urandom;
        #3;
        sample({tag, ".c0"}, is_mem && !mis, 1'b0);
        @(posedge clk); #1;
        if (is_mem && !mis) begin
            for (int k = 0; k <= lat; k++) begin
                dmem_ready_i = (k == lat);
                dmem_rdata_i = (k == lat) ? rdata : $urandom;
                #3;
                sample({tag, ".acc"}, k != lat, 1'b1);
                chk({tag, ".we"}, 32'(dmem_we_o), 32'(wr));
                chk({tag, ".addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
                chk({tag, ".be"}, 32'(dmem_be_o), 32'(e_be));
                if (wr) chk({tag, ".wdata"}, dmem_wdata_o, e_wdata);
                @(posedge clk); #1;
            end
        end
        p_valid    = 1'b1;
        p_addr     = wba;
        p_mis      = mis;
        p_en       = (mis || wr) ? 1'b0 : wbe;
        p_chk_data = !mis && !wr;
        p_data     = is_mem ? e_load : addr;
    endtask

    initial begin
        logic [2:0] f3tab [7];
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
        rst = 1'b1; valid_i = 1'b0; alu_result_i = '0; store_data_i = '0; funct3_i = '0;
        mem_read_i = 1'b0; mem_write_i = 1'b0; wb_enable_i = 1'b0; wb_addr_i = '0;
        dmem_ready_i = 1'b0; dmem_rdata_i = '0;
        #1;
        chk("rst.stall", 32'(stall_o), 32'd0);
        chk("rst.req", 32'(dmem_req_o), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst.wb_data", wb_data_o, 32'd0);
        chk("rst.addr", dmem_addr_o, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run("add", 32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 0, 32'h0);
        bubble();
        run("sb", 32'h0000_0103, 32'hAABB_CCDD, 3'b000, 1'b0, 1'b1, 1'b0, 5'd7, 3, 32'h0);
        bubble();
        run("lb", 32'h0000_0002, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 5'd9, 1, 32'h0080_0000);
        run("lbu", 32'h0000_0002, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1, 5'd10, 0, 32'h0080_0000);
        run("lh_mis", 32'h0000_0001, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 5'd11, 0, 32'h0);
        run("lw", 32'h0000_0004, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd12, 0, 32'hDEAD_BEEF);
        run("lw_b2b", 32'h0000_0008, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 5'd13, 0, 32'h1357_9BDF);
        run("add_b2b", 32'h0000_00AA, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd14, 0, 32'h0);
        run("rdwr", 32'h0000_0012, 32'h0000_BEEF, 3'b001, 1'b1, 1'b1, 1'b1, 5'd15, 1, 32'h0);
        bubble();

        // Reset in the middle of an outstanding access.
        valid_i = 1'b1; alu_result_i = 32'h40; funct3_i = 3'b010; mem_read_i = 1'b1;
        mem_write_i = 1'b0; wb_enable_i = 1'b1; wb_addr_i = 5'd3; dmem_ready_i = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.req_before", 32'(dmem_req_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.stall", 32'(stall_o), 32'd0);
        chk("rstmid.req", 32'(dmem_req_o), 32'd0);
        chk("rstmid.be", 32'(dmem_be_o), 32'd0);
        chk("rstmid.wb_valid", 32'(wb_valid_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0; mem_read_i = 1'b0; dmem_ready_i = 1'b1;
        @(posedge clk); #1;
        bubble();
        bubble();

        for (int i = 0; i < 60; i++) begin
            logic [2:0] f3;
            logic       rd;
            logic       wr;
            int         sel;
            f3  = f3tab[$urandom_range(0, 6)];
            sel = $urandom_range(0, 3);
            rd  = (sel == 1) || (sel == 3);
            wr  = (sel == 2) || (sel == 3);
            run("rnd", {$urandom_range(0, 255), 2'(0)} | 32'($urandom_range(0, 3)),
                $urandom, f3, rd, wr, 1'($urandom), 5'($urandom), $urandom_range(0, 3),
                $urandom);
            if ($urandom_range(0, 9) < 3) bubble();
        end
        bubble();
        bubble();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the ALU result (used as the address), the reg2 store data, funct3, and the mem_read/mem_write/wb_enable controls.
- Drives a variable-latency data-memory port using a req/ready handshake, with byte-lane store alignment and load extract/sign-extension.
- Holds the upstream pipeline stalled while an access is outstanding, then presents a registered writeback bundle to the WB stage.

Parameters:
- DATA_WIDTH, 32, data and address width; only 32 is supported.
- REG_ADDR_W, 5, width of the writeback register address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- valid_i  input  1  EX presents a valid instruction this cycle.
- alu_result_i  input  32  ALU result; memory address for loads and stores.
- store_data_i  input  32  reg2 data for stores.
- funct3_i  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_read_i  input  1  load.
- mem_write_i  input  1  store.
- wb_enable_i  input  1  instruction writes the register file.
- wb_addr_i  input  5  destination register.
- stall_o  output  1  hold the upstream stages; EX contents must stay stable while high.
- dmem_req_o  output  1  memory request valid.
- dmem_we_o  output  1  write request.
- dmem_addr_o  output  32  word-aligned address, with bits [1:0] forced to 0.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  32  lane-shifted store data.
- dmem_ready_i  input  1  request accepted; for reads, dmem_rdata_i is valid in this same cycle.
- dmem_rdata_i  input  32  read word.
- wb_valid_o  output  1  writeback bundle valid, registered.
- wb_enable_o  output  1  registered wb_enable, gated by valid.
- wb_addr_o  output  5  registered destination register.
- wb_data_o  output  32  load result, or alu_result for non-memory instructions.
- misalign_o  output  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset: state=IDLE. All outputs are 0: stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, wb_valid_o, wb_enable_o, wb_addr_o, wb_data_o, misalign_o. Reset asserted mid-access abandons the request with no writeback and no stall.
- Misalignment check: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - On a misaligned access: no dmem request is issued, misalign_o pulses, wb_valid_o=1 with wb_enable_o forced to 0.
- Non-memory instruction (valid_i, neither mem_read_i nor mem_write_i): single cycle. The next cycle shows wb_valid_o=1, wb_data_o=alu_result_i, wb_enable_o=wb_enable_i. stall_o stays 0.
- mem_read_i and mem_write_i both set: treated as a store.
- States: IDLE, ACCESS.
  - IDLE -> ACCESS when valid_i is set with a memory op and the access is aligned.
  - stall_o is asserted combinationally in that same cycle, and stays high until ready is observed.
  - In ACCESS, dmem_req_o=1 and addr/be/wdata/we stay stable (latched at entry) until dmem_ready_i.
  - When dmem_ready_i=1: return to IDLE, stall_o drops in that cycle, and the WB bundle is registered at the edge.
  - A ready arriving in the first ACCESS cycle gives 2-cycle total latency (entry cycle + ACCESS cycle).
- Store byte lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: be = 4'b0011 << addr[1:0]; wdata = {2{half}}.
  - SW: be = 4'b1111.
- Loads: dmem_be_o=4'b1111, dmem_we_o=0. Extract the byte/half at addr[1:0] from dmem_rdata_i, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Stores: wb_enable_o=0.
- Undefined funct3 on a memory op: treated as a word access.
- wb_valid_o is high for exactly one cycle per retired instruction. It is 0 in bubbles and while stalled.
- dmem_ready_i is ignored in IDLE.

Test Plan:
- Reset mid-ACCESS: assert rst while dmem_req_o=1 -> all outputs 0 immediately; after release, no wb_valid_o pulse.
- ADD, alu_result=0x0000_1234, wb_addr=5 -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_addr_o=5, stall_o=0 throughout.
- SB with addr=0x103, data=0xAABBCCDD, ready after 3 ACCESS cycles:
  - dmem_addr_o=0x100, be=4'b1000, wdata=0xDDDDDDDD, held stable for all 3 cycles.
  - stall_o high for 4 cycles.
  - wb_enable_o=0.
- LB at addr=0x2, rdata=0x0080_0000 -> wb_data_o=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- LH at addr=0x1 -> misalign_o pulses, dmem_req_o stays 0, wb_enable_o=0. A following LW at 0x4 with immediate ready -> wb_data_o=rdata after 2 cycles.
- Back-to-back: LW (ready at 1st ACCESS cycle) then ADD held by stall -> the ADD retires exactly one cycle after the LW's wb_valid_o, with no duplicate or dropped writebacks.
